// File: rtl/matmul_sched_pkg.sv
// Shared types and default geometry for the matmul job scheduler.
// The counter width is fixed; element counts follow the default matrix shape.
package matmul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } state_e;

  localparam int DW_DEF   = 8;
  localparam int AROW_DEF = 8;
  localparam int BCOL_DEF = 5;
  localparam int K_DEF    = 4;

  localparam int A_ELEMS = AROW_DEF * K_DEF;
  localparam int B_ELEMS = K_DEF * BCOL_DEF;
  localparam int C_ELEMS = AROW_DEF * BCOL_DEF;

  localparam int C_DATA_WIDTH = 2 * DW_DEF + $clog2(K_DEF);
  localparam int CNT_W        = 16;

  function automatic int c_width(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

endpackage

// File: rtl/matmul_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; the pointer is owned by the caller.
// Search starts one past last_i so the last winner has lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  input  logic                       en_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic found;
  int   pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last_i) + k) % NUM_REQ;
      if (!found && en_i && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Shares one matrix multiplier between requesters, one job in flight.
// Accept -> issue pulse -> capture result -> valid/ready response.
module matmul_job_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int DATA_WIDTH       = DW_DEF,
  parameter int A_ROWS           = AROW_DEF,
  parameter int B_COLUMNS        = BCOL_DEF,
  parameter int A_COLUMNS_B_ROWS = K_DEF,
  parameter int C_DATA_WIDTH     = c_width(DATA_WIDTH, A_COLUMNS_B_ROWS),
  parameter int ID_WIDTH         = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [DATA_WIDTH-1:0]
    req_a_i [NUM_REQ][A_ROWS*A_COLUMNS_B_ROWS],
  input  logic [DATA_WIDTH-1:0]
    req_b_i [NUM_REQ][A_COLUMNS_B_ROWS*B_COLUMNS],
  output logic                    mm_valid_o,
  output logic [DATA_WIDTH-1:0]
    mm_a_o [A_ROWS*A_COLUMNS_B_ROWS],
  output logic [DATA_WIDTH-1:0]
    mm_b_o [A_COLUMNS_B_ROWS*B_COLUMNS],
  input  logic                    mm_valid_i,
  input  logic [C_DATA_WIDTH-1:0]
    mm_c_i [A_ROWS*B_COLUMNS],
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_WIDTH-1:0]     rsp_id_o,
  output logic [C_DATA_WIDTH-1:0]
    rsp_c_o [A_ROWS*B_COLUMNS],
  output logic                    busy_o,
  output logic [CNT_W-1:0]        jobs_done_o,
  output logic                    error_o
);

  localparam int AE = A_ROWS * A_COLUMNS_B_ROWS;
  localparam int BE = A_COLUMNS_B_ROWS * B_COLUMNS;
  localparam int CE = A_ROWS * B_COLUMNS;

  state_e                  state_q;
  logic [ID_WIDTH-1:0]     last_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ID_WIDTH-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]      gnt;
  logic [DATA_WIDTH-1:0]   a_q [AE];
  logic [DATA_WIDTH-1:0]   b_q [BE];
  logic [C_DATA_WIDTH-1:0] c_q [CE];
  logic                    mm_valid_q;
  logic                    rsp_valid_q;
  logic                    err_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;

  assign cnt_d = cnt_q + CNT_W'(1);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req_i (req_valid_i),
    .last_i(last_q),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      last_q      <= ID_WIDTH'(NUM_REQ - 1);
      id_q        <= '0;
      mm_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < AE; i++) a_q[i] <= '0;
      for (int i = 0; i < BE; i++) b_q[i] <= '0;
      for (int i = 0; i < CE; i++) c_q[i] <= '0;
    end else begin
      // a result pulse outside WAIT has no job to belong to
      if (mm_valid_i && state_q != WAIT) err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            for (int i = 0; i < AE; i++)
              a_q[i] <= req_a_i[gnt_idx][i];
            for (int i = 0; i < BE; i++)
              b_q[i] <= req_b_i[gnt_idx][i];
            id_q       <= gnt_idx;
            mm_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          mm_valid_q <= 1'b0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (mm_valid_i) begin
            for (int i = 0; i < CE; i++)
              c_q[i] <= mm_c_i[i];
            rsp_valid_q <= 1'b1;
            state_q     <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            last_q      <= id_q;
            cnt_q       <= cnt_d;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready_o = gnt;
  assign mm_valid_o  = mm_valid_q;
  assign mm_a_o      = a_q;
  assign mm_b_o      = b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = id_q;
  assign rsp_c_o     = c_q;
  assign busy_o      = (state_q != IDLE);
  assign jobs_done_o = cnt_q;
  assign error_o     = err_q;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Bench for matmul_job_scheduler with a 1-cycle multiplier model
// and a round-robin / matrix-product reference.
module tb_matmul_job_scheduler;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AR = 8;
  localparam int BC = 5;
  localparam int K  = 4;
  localparam int CW = 18;
  localparam int AE = AR * K;
  localparam int BE = K * BC;
  localparam int CE = AR * BC;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] req_a [N][AE];
  logic [DW-1:0] req_b [N][BE];
  logic          mm_valid_o;
  logic [DW-1:0] mm_a [AE];
  logic [DW-1:0] mm_b [BE];
  logic          mm_valid_i;
  logic [CW-1:0] mm_c [CE];
  logic          rsp_valid;
  logic          rsp_ready;
  logic [0:0]    rsp_id;
  logic [CW-1:0] rsp_c [CE];
  logic          busy;
  logic [15:0]   jobs_done;
  logic          error;

  logic          mv_q;
  logic          spur;
  logic [CW-1:0] mc_q [CE];

  int checks = 0;
  int failures = 0;
  int last_g = N - 1;
  int exp_done = 0;
  int w;
  logic [CW-1:0] exp_c [CE];

  always #5 clk = ~clk;

  matmul_job_scheduler dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .mm_valid_o (mm_valid_o),
    .mm_a_o     (mm_a),
    .mm_b_o     (mm_b),
    .mm_valid_i (mm_valid_i),
    .mm_c_i     (mm_c),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_id_o   (rsp_id),
    .rsp_c_o    (rsp_c),
    .busy_o     (busy),
    .jobs_done_o(jobs_done),
    .error_o    (error)
  );

  function automatic logic [CW-1:0] mul_elem(input int i, input int j);
    int unsigned s = 0;
    for (int k = 0; k < K; k++)
      s += int'(mm_a[i*K+k]) * int'(mm_b[k*BC+j]);
    return CW'(s);
  endfunction

  function automatic logic [CW-1:0] ref_elem(input int r, input int i, input int j);
    int unsigned s = 0;
    for (int k = 0; k < K; k++)
      s += int'(req_a[r][i*K+k]) * int'(req_b[r][k*BC+j]);
    return CW'(s);
  endfunction

  // multiplier stand-in: registered, one cycle latency, shares reset
  always @(posedge clk) begin
    if (reset) begin
      mv_q <= 1'b0;
    end else begin
      mv_q <= mm_valid_o;
      if (mm_valid_o)
        for (int i = 0; i < AR; i++)
          for (int j = 0; j < BC; j++)
            mc_q[i*BC+j] <= mul_elem(i, j);
    end
  end

  assign mm_valid_i = mv_q | spur;
  assign mm_c = mc_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pred(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last_g + k) % N]) return (last_g + k) % N;
    return -1;
  endfunction

  task automatic fill(input int r, input bit rnd, input logic [DW-1:0] av,
                      input logic [DW-1:0] bv);
    for (int k = 0; k < AE; k++) req_a[r][k] = rnd ? DW'($urandom) : av;
    for (int k = 0; k < BE; k++) req_b[r][k] = rnd ? DW'($urandom) : bv;
  endtask

  task automatic job(input int hold, input bit drop, input bit rnd);
    logic [N-1:0] eg;
    #1;
    w = pred(req_valid);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    rsp_ready = (hold == 0);
    for (int i = 0; i < AR; i++)
      for (int j = 0; j < BC; j++)
        exp_c[i*BC+j] = ref_elem(w, i, j);
    chk("grant", req_ready, eg);
    chk("busy_idle", busy, 0);
    @(posedge clk); #1;
    if (drop) req_valid = '0;
    chk("mm_valid_issue", mm_valid_o, 1);
    chk("ready_issue", req_ready, 0);
    chk("mm_a0", mm_a[0], req_a[w][0]);
    chk("mm_b_last", mm_b[BE-1], req_b[w][BE-1]);
    if (rnd) fill(w, 1'b1, '0, '0);
    @(posedge clk); #1;
    chk("mm_valid_wait", mm_valid_o, 0);
    chk("rsp_valid_wait", rsp_valid, 0);
    chk("busy_wait", busy, 1);
    @(posedge clk); #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, w);
    for (int k = 0; k < CE; k++) chk("rsp_c", rsp_c[k], exp_c[k]);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, w);
      chk("bp_c0", rsp_c[0], exp_c[0]);
      chk("bp_clast", rsp_c[CE-1], exp_c[CE-1]);
      chk("bp_ready", req_ready, 0);
    end
    if (hold > 0) rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_done++;
    last_g = w;
    chk("rsp_done", rsp_valid, 0);
    chk("jobs_done", jobs_done, exp_done);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    spur = 1'b0;
    for (int r = 0; r < N; r++) fill(r, 1'b0, '0, '0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_ready", req_ready, 0);
    chk("rst_mm_valid", mm_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_error", error, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_mm_a", mm_a[0], 0);
    chk("rst_rsp_c", rsp_c[0], 0);

    fill(0, 1'b0, 8'd1, 8'd2);
    req_valid = 2'b01;
    job(0, 1'b1, 1'b0);
    chk("single_c8", rsp_c[5], 8);

    fill(1, 1'b0, 8'd255, 8'd255);
    req_valid = 2'b10;
    job(0, 1'b1, 1'b0);
    chk("max_c", rsp_c[CE-1], 260100);

    fill(0, 1'b1, '0, '0);
    fill(1, 1'b1, '0, '0);
    req_valid = 2'b11;
    for (int n = 0; n < 6; n++) job(0, n == 5, 1'b1);

    req_valid = 2'b11;
    job(10, 1'b0, 1'b1);
    job(0, 1'b1, 1'b1);

    req_valid = 2'b01;
    job(0, 1'b1, 1'b1);

    req_valid = 2'b10;
    #1;
    chk("rw_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = '0;
    chk("rw_issue", mm_valid_o, 1);
    @(posedge clk); #1;
    chk("rw_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_g = N - 1;
    exp_done = 0;
    chk("rw_busy_after", busy, 0);
    chk("rw_jobs", jobs_done, 0);
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_mm_a", mm_a[0], 0);
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      chk("rw_no_rsp", rsp_valid, 0);
    end
    req_valid = 2'b11;
    job(0, 1'b1, 1'b1);

    chk("pre_spur_error", error, 0);
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    chk("spur_error", error, 1);
    chk("spur_busy", busy, 0);
    chk("spur_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    chk("spur_sticky", error, 1);
    chk("spur_jobs", jobs_done, exp_done);
    fill(0, 1'b1, '0, '0);
    req_valid = 2'b01;
    job(0, 1'b1, 1'b1);
    chk("spur_after_err", error, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
